// File: rtl/alu_issue_if.sv
// Handshake and payload bundle between the issue front end, the decode stage and the ALU.
// The slave view belongs to the decode stage; the master view drives it.
interface alu_issue_if;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  logic [31:0] i_rs1_val;
  logic [31:0] i_rs2_val;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_a;
  logic [31:0] o_b;
  logic [3:0]  o_op;
  logic [4:0]  o_rd;
  logic        o_illegal;

  modport slave (
    input  i_valid, i_instr, i_pc, i_rs1_val, i_rs2_val, i_ready,
    output o_ready, o_valid, o_a, o_b, o_op, o_rd, o_illegal
  );

  modport master (
    output i_valid, i_instr, i_pc, i_rs1_val, i_rs2_val, i_ready,
    input  o_ready, o_valid, o_a, o_b, o_op, o_rd, o_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// RV32I OP/OP-IMM/LUI/AUIPC decode into ALU operands, held in an output register
// plus one skid register so the upstream ready is purely registered.
module alu_issue (
  input  logic        i_clk,
  input  logic        i_rst_n,
  alu_issue_if.slave  bus
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } entry_t;

  function automatic logic [3:0] f3_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SRL;
      3'b110:  op = OP_OR;
      3'b111:  op = OP_AND;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  entry_t     dec;

  assign opc = bus.i_instr[6:0];
  assign f3  = bus.i_instr[14:12];
  assign f7  = bus.i_instr[31:25];

  always_comb begin
    dec     = '0;
    dec.op  = OP_ADD;
    dec.rd  = bus.i_instr[11:7];
    dec.ill = 1'b0;
    case (opc)
      OPC_OP: begin
        dec.a  = bus.i_rs1_val;
        dec.b  = bus.i_rs2_val;
        dec.op = f3_op(f3);
        if (f7 == F7_ALT) begin
          if (f3 == 3'b000)      dec.op  = OP_SUB;
          else if (f3 == 3'b101) dec.op  = OP_SRA;
          else                   dec.ill = 1'b1;
        end else if (f7 != F7_BASE) begin
          dec.ill = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec.a  = bus.i_rs1_val;
        dec.b  = {{20{bus.i_instr[31]}}, bus.i_instr[31:20]};
        dec.op = f3_op(f3);
        // Shifts take only the shamt; the upper immediate bits select SRL/SRA.
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.b = {27'b0, bus.i_instr[24:20]};
          if (f3 == 3'b101 && f7 == F7_ALT) dec.op  = OP_SRA;
          else if (f7 != F7_BASE)           dec.ill = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.a = '0;
        dec.b = {bus.i_instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        dec.a = bus.i_pc;
        dec.b = {bus.i_instr[31:12], 12'b0};
      end
      default: dec.ill = 1'b1;
    endcase
    if (dec.ill) begin
      dec.a  = '0;
      dec.b  = '0;
      dec.op = OP_ADD;
      dec.rd = '0;
    end
  end

  entry_t or_q, or_d;
  entry_t sk_q, sk_d;
  logic   or_vld_q, or_vld_d;
  logic   sk_vld_q, sk_vld_d;
  logic   rdy_q, rdy_d;
  logic   acc, drn;

  assign acc = bus.i_valid && rdy_q;
  assign drn = or_vld_q && bus.i_ready;

  always_comb begin
    or_d     = or_q;
    sk_d     = sk_q;
    or_vld_d = or_vld_q;
    sk_vld_d = sk_vld_q;
    // With SK full, rdy_q is low, so a refill from SK never races a new accept.
    if (drn) begin
      if (sk_vld_q) begin
        or_d     = sk_q;
        sk_vld_d = 1'b0;
      end else if (acc) begin
        or_d = dec;
      end else begin
        or_vld_d = 1'b0;
      end
    end else if (acc) begin
      if (!or_vld_q) begin
        or_d     = dec;
        or_vld_d = 1'b1;
      end else begin
        sk_d     = dec;
        sk_vld_d = 1'b1;
      end
    end
    rdy_d = !sk_vld_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      or_q     <= '0;
      sk_q     <= '0;
      or_vld_q <= 1'b0;
      sk_vld_q <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      or_q     <= or_d;
      sk_q     <= sk_d;
      or_vld_q <= or_vld_d;
      sk_vld_q <= sk_vld_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.o_ready   = rdy_q;
  assign bus.o_valid   = or_vld_q;
  assign bus.o_a       = or_q.a;
  assign bus.o_b       = or_q.b;
  assign bus.o_op      = or_q.op;
  assign bus.o_rd      = or_q.rd;
  assign bus.o_illegal = or_q.ill;

endmodule

// File: tb/tb_alu_issue.sv
// Randomised and directed bench for alu_issue against a queue-based reference model.
module tb_alu_issue;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3, A_SLTU = 4'd4;
  localparam logic [3:0] A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_OR = 4'd8, A_AND = 4'd9;
  localparam logic [3:0] BASE_OP [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  alu_issue_if bus();

  alu_issue dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];
  bit   rdy_ok = 1'b0;
  bit   post_rst = 1'b0;
  bit   last_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] mk_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  // Reference decode: legality first, then operands from the instruction format.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    bit legal;
    bit is_op = (opc == 7'b0110011);
    bit is_imm = (opc == 7'b0010011);
    bit is_u = (opc == 7'b0110111) || (opc == 7'b0010111);
    if (is_op)       legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    else if (is_imm) legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                             (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
    else             legal = is_u;
    e.a = 0; e.b = 0; e.op = A_ADD; e.rd = 0; e.ill = 1'b1;
    if (!legal) return e;
    e.ill = 1'b0;
    e.rd  = ins[11:7];
    if (is_u) begin
      e.a = (opc == 7'b0010111) ? pc : 32'd0;
      e.b = ins[31:12] << 12;
      return e;
    end
    e.op = BASE_OP[f3];
    if (f7 == 7'h20 && f3 == 3'd5) e.op = A_SRA;
    if (is_op && f7 == 7'h20 && f3 == 3'd0) e.op = A_SUB;
    e.a = r1;
    if (is_op) e.b = r2;
    else if (f3 == 3'd1 || f3 == 3'd5) e.b = 32'(ins[24:20]);
    else e.b = 32'($signed(ins[31:20]));
    return e;
  endfunction

  // One cycle: check current outputs against the model, drive inputs, advance the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2, input logic rdy, input logic rn);
    bit exp_rdy, acc, drn;
    @(negedge clk);
    chk("o_valid", 32'(bus.o_valid), 32'(q.size() > 0));
    chk("o_ready", 32'(bus.o_ready), 32'(rdy_ok && q.size() < 2));
    if (q.size() > 0) begin
      chk("o_a", bus.o_a, q[0].a);
      chk("o_b", bus.o_b, q[0].b);
      chk("o_op", 32'(bus.o_op), 32'(q[0].op));
      chk("o_rd", 32'(bus.o_rd), 32'(q[0].rd));
      chk("o_illegal", 32'(bus.o_illegal), 32'(q[0].ill));
    end else if (post_rst) begin
      chk("rst_a", bus.o_a, 32'd0);
      chk("rst_b", bus.o_b, 32'd0);
      chk("rst_op_rd_ill", {23'd0, bus.o_op, bus.o_rd}, {23'd0, A_ADD, 5'd0});
      chk("rst_ill", 32'(bus.o_illegal), 32'd0);
    end
    bus.i_valid = v; bus.i_instr = ins; bus.i_pc = pc;
    bus.i_rs1_val = r1; bus.i_rs2_val = r2; bus.i_ready = rdy; rst_n = rn;
    if (!rn) begin
      q.delete(); rdy_ok = 1'b0; post_rst = 1'b1; last_acc = 1'b0;
    end else begin
      exp_rdy = rdy_ok && q.size() < 2;
      acc = v && exp_rdy;
      drn = (q.size() > 0) && rdy;
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(ref_dec(ins, pc, r1, r2));
      rdy_ok = 1'b1; post_rst = 1'b0; last_acc = acc;
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, rdy, 1'b1);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0] opc, f7;
    case ($urandom_range(0, 6))
      0, 1:    opc = 7'b0110011;
      2, 3:    opc = 7'b0010011;
      4:       opc = 7'b0110111;
      5:       opc = 7'b0010111;
      default: opc = ($urandom_range(0, 1) != 0) ? 7'b0000011 : 7'($urandom);
    endcase
    case ($urandom_range(0, 5))
      0, 1, 2: f7 = 7'h00;
      3:       f7 = 7'h20;
      4:       f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
  endfunction

  logic [31:0] prog [20];
  logic [31:0] bp   [3];
  exp_t        e;
  int          idx;
  int          cyc;
  int          n_acc;

  initial begin
    bus.i_valid = 0; bus.i_instr = 0; bus.i_pc = 0; bus.i_rs1_val = 0;
    bus.i_rs2_val = 0; bus.i_ready = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    post_rst = 1'b1;

    // Pin the reference model with hand-computed decodes.
    e = ref_dec(mk_i(12'hFFF, 5'd1, 3'd0, 5'd5, 7'b0010011), 0, 32'd7, 0);
    chk("model_addi", e.b ^ e.a, 32'hFFFFFFF8);
    chk("model_addi_rd", {22'd0, e.op, e.rd, e.ill}, {22'd0, A_ADD, 5'd5, 1'b0});
    e = ref_dec(mk_i(12'h41F, 5'd2, 3'd5, 5'd3, 7'b0010011), 0, 32'h80000000, 0);
    chk("model_srai", {e.b[27:0], e.op}, {28'd31, A_SRA});
    e = ref_dec(mk_u(20'h12345, 5'd4, 7'b0110111), 32'h100, 32'h55, 0);
    chk("model_lui", e.b + e.a, 32'h12345000);
    e = ref_dec(mk_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd6, 7'b0110011), 0, 32'h9, 32'h9);
    chk("model_mul", {e.a[15:0], 11'd0, e.rd, e.ill}, {16'd0, 11'd0, 5'd0, 1'b1});

    step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);

    // Full-rate stream of R and I forms.
    for (int i = 0; i < 10; i++) begin
      logic [2:0] f3s [10] = '{3'd0, 3'd0, 3'd5, 3'd3, 3'd4, 3'd6, 3'd7, 3'd1, 3'd5, 3'd2};
      logic [6:0] f7s [10] = '{7'h00, 7'h20, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
      prog[i]      = mk_r(f7s[i], 5'd3, 5'd2, f3s[i], 5'(i + 1), 7'b0110011);
      prog[i + 10] = mk_i({f7s[i], 5'(i + 3)}, 5'd2, f3s[i], 5'(i + 11), 7'b0010011);
    end
    foreach (prog[i]) step(1'b1, prog[i], 32'h40 + 32'(i * 4), $urandom, $urandom, 1'b1, 1'b1);

    step(1'b1, mk_i(12'hFFF, 5'd1, 3'd0, 5'd5, 7'b0010011), 0, 32'd7, 0, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("addi_b", bus.o_b, 32'hFFFFFFFF);
    chk("addi_a_rd", {bus.o_a[26:0], bus.o_rd}, {27'd7, 5'd5});
    step(1'b1, mk_i(12'h41F, 5'd2, 3'd5, 5'd3, 7'b0010011), 0, 32'h80000000, 0, 1'b1, 1'b1);
    step(1'b1, mk_u(20'h12345, 5'd4, 7'b0110111), 32'h100, 32'h77, 0, 1'b1, 1'b1);
    step(1'b1, mk_u(20'hABCDE, 5'd8, 7'b0010111), 32'h100, 32'h77, 0, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("auipc_a", bus.o_a, 32'h100);
    chk("auipc_b", bus.o_b, 32'hABCDE000);
    step(1'b1, mk_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd6, 7'b0110011), 0, 32'h9, 32'h9, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("mul_illegal", {bus.o_b[15:0], 11'd0, bus.o_rd, bus.o_illegal}, {16'd0, 11'd0, 5'd0, 1'b1});
    step(1'b1, mk_i(12'h401, 5'd1, 3'd1, 5'd7, 7'b0010011), 0, 32'h9, 0, 1'b1, 1'b1);
    step(1'b1, mk_i(12'h004, 5'd1, 3'd2, 5'd9, 7'b0000011), 0, 32'h9, 0, 1'b1, 1'b1);
    step(1'b1, mk_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd0, 7'b0110011), 0, 32'h3, 32'h4, 1'b1, 1'b1);
    idle(1'b1);

    // Back-pressure: three offered while the consumer stalls for five cycles.
    bp[0] = mk_r(7'h00, 5'd1, 5'd2, 3'd4, 5'd10, 7'b0110011);
    bp[1] = mk_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd11, 7'b0110011);
    bp[2] = mk_i(12'h123, 5'd2, 3'd6, 5'd12, 7'b0010011);
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, bp[idx], 0, 32'h1111 * 32'(idx + 1), 32'h2222, 1'b0, 1'b1);
      if (last_acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    @(posedge clk); #1;
    chk("bp_ready_low", 32'(bus.o_ready), 32'd0);
    chk("bp_head_rd", 32'(bus.o_rd), 32'd10);
    for (int i = 0; i < 6 && idx < 3; i++) begin
      step(1'b1, bp[idx], 0, 32'h1111 * 32'(idx + 1), 32'h2222, 1'b1, 1'b1);
      if (last_acc) idx++;
    end
    chk("bp_all_accepted", 32'(idx), 32'd3);
    repeat (3) idle(1'b1);

    // Randomised handshake over 10,000 instructions.
    n_acc = 0;
    cyc = 0;
    while (n_acc < 10000 && cyc < 40000) begin
      step(1'($urandom_range(0, 9) < 7), rnd_instr(), $urandom, $urandom, $urandom,
           1'($urandom_range(0, 9) < 6), 1'b1);
      if (last_acc) n_acc++;
      cyc++;
    end
    chk("rand_budget", 32'(n_acc), 32'd10000);
    for (int i = 0; i < 8 && q.size() > 0; i++) idle(1'b1);
    chk("rand_drained", 32'(q.size()), 32'd0);

    // Reset with two entries held.
    step(1'b1, bp[0], 0, 32'h5, 32'h6, 1'b0, 1'b1);
    step(1'b1, bp[1], 0, 32'h5, 32'h6, 1'b0, 1'b1);
    step(1'b1, bp[2], 0, 32'h5, 32'h6, 1'b0, 1'b1);
    chk("rst_held", 32'(q.size()), 32'd2);
    step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("rst_valid_low", 32'(bus.o_valid), 32'd0);
    step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("rst_ready_back", 32'(bus.o_ready), 32'd1);
    repeat (3) idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Operand-select and decode stage directly upstream of the RV32I integer ALU. Each cycle it accepts one instruction word with its PC and register-file read values. It decodes the OP, OP-IMM, LUI and AUIPC formats into the ALU's operand A, operand B and 4-bit op code, and presents them in a registered, back-pressurable output with a 2-entry skid buffer. Downstream (the ALU and writeback) sees a clean valid/ready stream with no combinational path from its ready back to the upstream ready.

## Interface
- No parameters; all widths are fixed at RV32 (32-bit data, 5-bit rd, 4-bit op).
- i_clk  in  1  single clock; everything is sampled on the rising edge
- i_rst_n  in  1  reset, synchronous and active-low
- i_valid  in  1  upstream has an instruction
- o_ready  out  1  stage can accept; driven from a register
- i_instr  in  32  RV32I instruction word
- i_pc  in  32  PC of i_instr
- i_rs1_val  in  32  register-file value of rs1
- i_rs2_val  in  32  register-file value of rs2
- o_valid  out  1  decoded entry available
- i_ready  in  1  downstream accepts
- o_a  out  32  ALU operand A
- o_b  out  32  ALU operand B
- o_op  out  4  ALU op code, using the shared ALU op macros (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND)
- o_rd  out  5  destination register
- o_illegal  out  1  entry is not a supported instruction

## Operation
- Opcode i_instr[6:0]:
  - 0110011 OP: a=rs1_val, b=rs2_val.
  - 0010011 OP-IMM: a=rs1_val; b=sign-extended instr[31:20]; for shifts, b={27'b0, instr[24:20]}.
  - 0110111 LUI: a=0, b={instr[31:12],12'b0}, op=ADD.
  - 0010111 AUIPC: a=i_pc, b={instr[31:12],12'b0}, op=ADD.
- funct3 i_instr[14:12] maps to the op code:
  - 000 → ADD, or SUB only for OP with funct7=0100000.
  - 001 → SLL. funct7 (OP) or imm[11:5] (OP-IMM) must be 0000000, else illegal.
  - 010 → SLT; 011 → SLTU; 100 → XOR; 110 → OR; 111 → AND.
  - 101 → SRL when funct7/imm[11:5]=0000000, SRA when 0100000, else illegal.
- Further rules for OP:
  - funct7 other than 0000000/0100000 is illegal; this includes M-extension 0000001.
  - 0100000 with funct3 other than 000/101 is illegal.
  - OP-IMM ignores funct7 except for shifts.
- o_rd = instr[11:7]; rd=0 is passed through unchanged.
- Illegal or unsupported opcode: the entry is still forwarded, with o_illegal=1, o_op=ADD, o_a=o_b=0, o_rd=0. It is never dropped.
- Buffering:
  - Output register (OR) plus one skid register (SK).
  - Accept = i_valid && o_ready. Decoded data goes to OR if OR is empty or is draining this cycle; otherwise it goes to SK.
  - When OR drains and SK is full, SK moves to OR.
  - o_ready is registered = !SK_full_next.
  - Strict FIFO order; no duplication or loss.

## Timing
- Reset (i_rst_n low at an edge):
  - o_valid=0, o_ready=0, o_a=o_b=0, o_op=ADD, o_rd=0, o_illegal=0; SK is emptied.
  - The first edge with i_rst_n high sets o_ready=1.
  - Reset mid-stream discards both entries; no partial entry survives.
- Latency: instruction accepted at edge N → o_valid with its data after edge N.
- Throughput: 1 per cycle with i_ready held high. o_ready stays 1 and SK stays empty.
- Stall: i_ready low while OR is full and an accept occurs → the entry goes to SK and o_ready drops after that edge. At most 2 entries are held.
- Release: the first edge with i_ready high drains OR and loads SK into OR. o_ready rises after that edge and SK is empty. A new accept in that same cycle is impossible because o_ready is 0.
- While o_valid && !i_ready, o_a, o_b, o_op, o_rd and o_illegal stay constant.
- Outputs depend only on registers; no combinational path from i_* to o_*.

## Test plan
- Reset, then stream at full rate with i_ready=1: ADD, SUB, SRA, SLTU, XOR, OR, AND, SLL, SRL, SLT (OP and OP-IMM forms) → one output per cycle, 1-cycle latency, operands/op correct, o_ready never low.
- OP-IMM `addi x5,x1,-1`, rs1_val=7 → o_a=7, o_b=0xFFFFFFFF, op ADD, rd=5. `srai x3,x2,31` → o_b=31, op SRA. LUI 0x12345 → a=0, b=0x12345000. AUIPC at pc=0x100 → a=0x100.
- Illegal cases: funct7=0000001 (MUL), slli with imm[11:5]=0100000, opcode 0000011 (load) → o_illegal=1, op ADD, a=b=0, rd=0, order preserved.
- Back-pressure: i_ready=0 for 5 cycles while 3 instructions are offered → 2 accepted, o_ready low after the second, outputs stable. Raising i_ready drains them in order, then the third is accepted.
- Randomised i_valid/i_ready over 10,000 instructions, checked against a reference decode queue → no loss, duplication or reorder.
- Assert i_rst_n low with 2 entries held → o_valid=0 next cycle, o_ready=1 one cycle after reset is released, and no stale entry emerges.
